alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mul_seq.sv | 42 ++++
 rtl/alu_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag-bit positions and pipeline states shared by alu_pipe and its bench
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHR = 4'd6,
    OP_SHL = 4'd7,
    OP_MUL = 4'd8
  } op_e;
  localparam int F_ZERO  = 0;
  localparam int F_CARRY = 1;
  localparam int F_NEG   = 2;
  localparam int F_OVF   = 3;
  localparam int F_ERR   = 4;
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-cycle shift-add multiplier, the first iteration runs on the start edge
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mc;
  logic [CW-1:0] cnt;
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{p[0]}}};
    return {s, p[WIDTH-1:1]};
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc <= '0;
      cnt <= '0;
      prod <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      mc <= a;
      prod <= step({{WIDTH{1'b0}}, b}, a);
      cnt <= CW'(1);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      prod <= step(prod, mc);
      cnt <= cnt + 1'b1;
      busy <= cnt != CW'(WIDTH - 1);
      done <= cnt == CW'(WIDTH - 1);
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: one-slot registered ALU with valid/ready handshake; ALU_PIPE_MUL_EN adds a sequential MUL
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);
  state_e state, state_nx;
  logic live, free, accept, ld;
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] alu_r, r;
  logic alu_c, alu_v, alu_e, c, v, e;
  assign free = !out_valid || out_ready;
  assign in_ready = live && state == IDLE && free;
  assign accept = in_valid && in_ready;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (opcode)
      OP_W'(OP_ADD): begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_W'(OP_SUB): begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_W'(OP_AND): alu_r = a & b;
      OP_W'(OP_OR):  alu_r = a | b;
      OP_W'(OP_XOR): alu_r = a ^ b;
      OP_W'(OP_NOT): alu_r = ~a;
      OP_W'(OP_SHR): begin
        alu_r = a >> 1;
        alu_c = a[0];
      end
      OP_W'(OP_SHL): begin
        alu_r = a << 1;
        alu_c = a[WIDTH-1];
      end
      default: alu_e = 1'b1;
    endcase
  end
`ifdef ALU_PIPE_MUL_EN
  logic is_mul, busy, done, mul_ld;
  logic [2*WIDTH-1:0] prod;
  assign is_mul = opcode == OP_W'(OP_MUL);
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );
  assign mul_ld = free && (state == HOLD || (state == MUL && done && !busy));
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept && is_mul) state_nx = MUL;
    else if (state == MUL && done && !busy) state_nx = free ? IDLE : HOLD;
    else if (state == HOLD && free) state_nx = IDLE;
  end
  assign ld = mul_ld || (accept && !is_mul);
  assign r = mul_ld ? prod[WIDTH-1:0] : alu_r;
  assign c = mul_ld ? |prod[2*WIDTH-1:WIDTH] : alu_c;
  assign v = mul_ld ? 1'b0 : alu_v;
  assign e = mul_ld ? 1'b0 : alu_e;
`else
  assign state_nx = IDLE;
  assign ld = accept;
  assign r = alu_r;
  assign c = alu_c;
  assign v = alu_v;
  assign e = alu_e;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      out_valid <= ld || (out_valid && !out_ready);
      if (ld) begin
        result <= r;
        flags[F_ERR] <= e;
        flags[F_OVF] <= v;
        flags[F_NEG] <= r[WIDTH-1];
        flags[F_CARRY] <= c;
        flags[F_ZERO] <= r == '0;
      end
    end
  end
endmodule
